// File: rtl/c7bexu_issue_sb.sv
// Dual-issue hazard scoreboard and issue controller for the 2W/6R register file.
// Tracks a pending-write countdown per register and a write-port reservation
// table. It grants an in-order slot pair (slot0 older) so that no more than two
// RF writes land in one cycle and writes to a register never reorder.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             suppresses both grants this cycle
//   i0_* / i1_*       slot0 / slot1 instruction fields (valid, sources, dest, latency)
//   issue0, issue1    combinational grants for slot0 / slot1
//   stall             slot0 valid but not granted
//   busy              registered; bit r set while register r has more than one cycle to go
module c7bexu_issue_sb #(
    parameter int unsigned MAX_LAT = 7,
    parameter int unsigned LW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i0_valid,
    input  logic [4:0]    i0_src0,
    input  logic [4:0]    i0_src1,
    input  logic          i0_src0_en,
    input  logic          i0_src1_en,
    input  logic [4:0]    i0_dst,
    input  logic          i0_dst_we,
    input  logic [LW-1:0] i0_lat,
    input  logic          i1_valid,
    input  logic [4:0]    i1_src0,
    input  logic [4:0]    i1_src1,
    input  logic          i1_src0_en,
    input  logic          i1_src1_en,
    input  logic [4:0]    i1_dst,
    input  logic          i1_dst_we,
    input  logic [LW-1:0] i1_lat,
    output logic          issue0,
    output logic          issue1,
    output logic          stall,
    output logic [31:0]   busy
);

    logic [LW-1:0] cnt       [32];
    logic [LW-1:0] cnt_next  [32];
    logic [1:0]    resv      [1:MAX_LAT-1];
    logic [1:0]    resv_next [1:MAX_LAT-1];
    logic [31:0]   busy_next;

    logic       i0_eff, i1_eff;
    logic       i0_src_ok, i1_src_ok;
    logic       i0_waw_ok, i1_waw_ok;
    logic       i0_port_ok, i1_port_ok;
    logic [1:0] resv_at0, resv_at1;
    logic       pair_same_lat;
    logic       intra_conflict;
    logic       w0, w1;

    // r0 is hardwired; it never goes busy and never takes a write port
    assign i0_eff = i0_dst_we && (i0_dst != 5'd0);
    assign i1_eff = i1_dst_we && (i1_dst != 5'd0);

    // cnt == 1 means the producer writes this cycle and is forwarded
    assign i0_src_ok = (!i0_src0_en || (i0_src0 == 5'd0) || (cnt[i0_src0] <= LW'(1))) &&
                       (!i0_src1_en || (i0_src1 == 5'd0) || (cnt[i0_src1] <= LW'(1)));
    assign i1_src_ok = (!i1_src0_en || (i1_src0 == 5'd0) || (cnt[i1_src0] <= LW'(1))) &&
                       (!i1_src1_en || (i1_src1 == 5'd0) || (cnt[i1_src1] <= LW'(1)));

    // a new write must not land before an older pending write to the same register
    assign i0_waw_ok = !i0_eff || (cnt[i0_dst] <= i0_lat);
    assign i1_waw_ok = !i1_eff || (cnt[i1_dst] <= i1_lat);

    // reservation count for each slot's landing cycle
    always_comb begin
        resv_at0 = 2'd0;
        resv_at1 = 2'd0;
        for (int unsigned k = 1; k < MAX_LAT; k++) begin
            if (i0_lat == LW'(k)) resv_at0 = resv[k];
            if (i1_lat == LW'(k)) resv_at1 = resv[k];
        end
    end

    // the MAX_LAT landing slot is always empty at issue time
    assign i0_port_ok    = !i0_eff || (i0_lat == LW'(MAX_LAT)) || (resv_at0 <= 2'd1);
    assign pair_same_lat = issue0 && i0_eff && (i0_lat == i1_lat);
    assign i1_port_ok    = !i1_eff || (i1_lat == LW'(MAX_LAT)) ||
                           ((3'(resv_at1) + 3'(pair_same_lat)) <= 3'd1);

    // no forwarding inside the pair, and no same-destination pair
    assign intra_conflict = (i0_eff && i1_src0_en && (i1_src0 != 5'd0) && (i1_src0 == i0_dst)) ||
                            (i0_eff && i1_src1_en && (i1_src1 != 5'd0) && (i1_src1 == i0_dst)) ||
                            (i0_eff && i1_eff && (i0_dst == i1_dst));

    assign issue0 = !rst && i0_valid && !flush && i0_src_ok && i0_waw_ok && i0_port_ok;
    assign issue1 = issue0 && i1_valid && i1_src_ok && i1_waw_ok && i1_port_ok && !intra_conflict;
    assign stall  = !rst && i0_valid && !issue0;

    assign w0 = issue0 && i0_eff;
    assign w1 = issue1 && i1_eff;

    // countdown update: a granted write reloads its register, others count to zero
    always_comb begin
        cnt_next[0]  = '0;
        busy_next    = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            if (w0 && (i0_dst == 5'(r))) begin
                cnt_next[r] = i0_lat;
            end else if (w1 && (i1_dst == 5'(r))) begin
                cnt_next[r] = i1_lat;
            end else if (cnt[r] != '0) begin
                cnt_next[r] = cnt[r] - LW'(1);
            end else begin
                cnt_next[r] = '0;
            end
            busy_next[r] = cnt_next[r] > LW'(1);
        end
    end

    // reservation table shifts one slot closer each cycle; L == 1 writes are not stored
    always_comb begin
        for (int unsigned k = 1; k < MAX_LAT - 1; k++) begin
            resv_next[k] = resv[k+1] +
                           2'(w0 && (i0_lat == LW'(k + 1))) +
                           2'(w1 && (i1_lat == LW'(k + 1)));
        end
        resv_next[MAX_LAT-1] = 2'(w0 && (i0_lat == LW'(MAX_LAT))) +
                               2'(w1 && (i1_lat == LW'(MAX_LAT)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
            for (int unsigned k = 1; k < MAX_LAT; k++) resv[k] <= 2'd0;
            busy <= '0;
        end else begin
            cnt  <= cnt_next;
            resv <= resv_next;
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_c7bexu_issue_sb.sv
// Directed bench for c7bexu_issue_sb: grants, stalls, busy timing, port and
// WAW hazards, intra-pair conflicts, flush and mid-run reset.
module tb_c7bexu_issue_sb;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        i0_valid, i0_src0_en, i0_src1_en, i0_dst_we;
    logic [4:0]  i0_src0, i0_src1, i0_dst;
    logic [2:0]  i0_lat;
    logic        i1_valid, i1_src0_en, i1_src1_en, i1_dst_we;
    logic [4:0]  i1_src0, i1_src1, i1_dst;
    logic [2:0]  i1_lat;
    logic        issue0, issue1, stall;
    logic [31:0] busy;

    int total  = 0;
    int passed = 0;

    c7bexu_issue_sb #(.MAX_LAT(7), .LW(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i0_valid(i0_valid), .i0_src0(i0_src0), .i0_src1(i0_src1),
        .i0_src0_en(i0_src0_en), .i0_src1_en(i0_src1_en),
        .i0_dst(i0_dst), .i0_dst_we(i0_dst_we), .i0_lat(i0_lat),
        .i1_valid(i1_valid), .i1_src0(i1_src0), .i1_src1(i1_src1),
        .i1_src0_en(i1_src0_en), .i1_src1_en(i1_src1_en),
        .i1_dst(i1_dst), .i1_dst_we(i1_dst_we), .i1_lat(i1_lat),
        .issue0(issue0), .issue1(issue1), .stall(stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero latency is illegal input
    always @(posedge clk) begin
        assert (!(i0_valid && i0_lat == 3'd0)) else $error("slot0 zero latency");
        assert (!(i1_valid && i1_lat == 3'd0)) else $error("slot1 zero latency");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [4:0] s0, input logic s0e,
                        input logic [4:0] s1, input logic s1e,
                        input logic [4:0] d, input logic we, input logic [2:0] lat);
        i0_valid = v; i0_src0 = s0; i0_src0_en = s0e; i0_src1 = s1; i0_src1_en = s1e;
        i0_dst = d; i0_dst_we = we; i0_lat = lat;
    endtask

    task automatic set1(input logic v, input logic [4:0] s0, input logic s0e,
                        input logic [4:0] s1, input logic s1e,
                        input logic [4:0] d, input logic we, input logic [2:0] lat);
        i1_valid = v; i1_src0 = s0; i1_src0_en = s0e; i1_src1 = s1; i1_src1_en = s1e;
        i1_dst = d; i1_dst_we = we; i1_lat = lat;
    endtask

    task automatic idle();
        flush = 1'b0;
        set0(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        set1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        tick(); #2;
        total++; if (issue0 !== 1'b0) $display("FAIL rst_issue0: got %b want 0", issue0); else passed++;
        total++; if (issue1 !== 1'b0) $display("FAIL rst_issue1: got %b want 0", issue1); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else passed++;
        total++; if (busy !== 32'h0) $display("FAIL rst_busy: got %h want 0", busy); else passed++;
        rst = 1'b0; #2;
        total++; if (issue0 !== 1'b1) $display("FAIL post_rst_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b1) $display("FAIL post_rst_issue1: got %b want 1", issue1); else passed++;
        idle();
        tick(); #2;
        total++; if (busy !== 32'h0) $display("FAIL post_rst_busy: got %h want 0", busy); else passed++;
    endtask

    task automatic test_fwd_l1();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd1);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL fwd_prod_issue: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL fwd_cons_issue: got %b want 1", issue0); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL fwd_cons_stall: got %b want 0", stall); else passed++;
        total++; if (busy[3] !== 1'b0) $display("FAIL fwd_busy3_a: got %b want 0", busy[3]); else passed++;
        tick(); idle(); #2;
        total++; if (busy[3] !== 1'b0) $display("FAIL fwd_busy3_b: got %b want 0", busy[3]); else passed++;
    endtask

    task automatic test_load_use();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd3);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL lu_load_issue: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        for (int i = 0; i < 2; i++) begin
            #2;
            total++; if (stall !== 1'b1) $display("FAIL lu_stall_%0d: got %b want 1", i, stall); else passed++;
            total++; if (busy[5] !== 1'b1) $display("FAIL lu_busy5_%0d: got %b want 1", i, busy[5]); else passed++;
            tick();
        end
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL lu_use_issue: got %b want 1", issue0); else passed++;
        total++; if (busy[5] !== 1'b0) $display("FAIL lu_busy5_end: got %b want 0", busy[5]); else passed++;
        tick(); idle();
    endtask

    task automatic test_intra_pair();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd1);
        set1(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd1);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL raw_pair_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b0) $display("FAIL raw_pair_issue1: got %b want 0", issue1); else passed++;
        tick();
        set0(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd1);
        set1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL raw_replay_issue0: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd2);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd3);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL samedst_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b0) $display("FAIL samedst_issue1: got %b want 0", issue1); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 3'd1);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 3'd2);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL dual_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b1) $display("FAIL dual_issue1: got %b want 1", issue1); else passed++;
        tick(); idle(); #2;
        total++; if (busy[15] !== 1'b1) $display("FAIL dual_busy15: got %b want 1", busy[15]); else passed++;
        total++; if (busy[13] !== 1'b0) $display("FAIL dual_busy13: got %b want 0", busy[13]); else passed++;
    endtask

    task automatic test_port();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 3'd4);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL port_mul8: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd3);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL port_pair_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b0) $display("FAIL port_pair_issue1: got %b want 0", issue1); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd2);
        set1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        #2;
        total++; if (issue0 !== 1'b0) $display("FAIL port_full_issue0: got %b want 0", issue0); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL port_full_stall: got %b want 1", stall); else passed++;
        tick(); #2;
        total++; if (issue0 !== 1'b1) $display("FAIL port_free_issue0: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd17, 1'b1, 3'd7);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd18, 1'b1, 3'd7);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL maxlat_issue0: got %b want 1", issue0); else passed++;
        total++; if (issue1 !== 1'b1) $display("FAIL maxlat_issue1: got %b want 1", issue1); else passed++;
        tick(); idle();
    endtask

    task automatic test_waw();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd5);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL waw_mul_issue: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1);
        #2;
        total++; if (busy[7] !== 1'b1) $display("FAIL waw_busy7: got %b want 1", busy[7]); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (issue0 !== 1'b0) $display("FAIL waw_block_%0d: got %b want 0", i, issue0); else passed++;
            tick(); #2;
        end
        total++; if (issue0 !== 1'b1) $display("FAIL waw_release: got %b want 1", issue0); else passed++;
        tick(); idle(); #2;
        total++; if (busy[7] !== 1'b0) $display("FAIL waw_busy7_end: got %b want 0", busy[7]); else passed++;
    endtask

    task automatic test_flush_rst();
        flush = 1'b1;
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd19, 1'b1, 3'd1);
        set1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 3'd1);
        #2;
        total++; if (issue0 !== 1'b0) $display("FAIL flush_issue0: got %b want 0", issue0); else passed++;
        total++; if (issue1 !== 1'b0) $display("FAIL flush_issue1: got %b want 0", issue1); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL flush_stall: got %b want 1", stall); else passed++;
        tick();
        idle();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 3'd3);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL flush_prod_issue: got %b want 1", issue0); else passed++;
        tick();
        flush = 1'b1;
        set0(1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        for (int i = 0; i < 2; i++) begin
            #2;
            total++; if (issue0 !== 1'b0) $display("FAIL flush_hold_%0d: got %b want 0", i, issue0); else passed++;
            total++; if (busy[21] !== 1'b1) $display("FAIL flush_busy21_%0d: got %b want 1", i, busy[21]); else passed++;
            tick();
        end
        flush = 1'b0;
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL flush_countdown_issue: got %b want 1", issue0); else passed++;
        tick();
        set0(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 3'd4);
        #2;
        total++; if (issue0 !== 1'b1) $display("FAIL rst_prod_issue: got %b want 1", issue0); else passed++;
        tick();
        rst = 1'b1;
        set0(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1);
        #2;
        total++; if (busy[2] !== 1'b1) $display("FAIL rst_busy2_pre: got %b want 1", busy[2]); else passed++;
        total++; if (issue0 !== 1'b0) $display("FAIL rst_mid_issue0: got %b want 0", issue0); else passed++;
        tick();
        rst = 1'b0;
        #2;
        total++; if (busy !== 32'h0) $display("FAIL rst_mid_busy: got %h want 0", busy); else passed++;
        total++; if (issue0 !== 1'b1) $display("FAIL rst_reader_issue: got %b want 1", issue0); else passed++;
        tick(); idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        drain();
        test_fwd_l1();
        drain();
        test_load_use();
        drain();
        test_intra_pair();
        drain();
        test_port();
        drain();
        test_waw();
        drain();
        test_flush_rst();
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
